// File: rtl/track_predictor_core_if.sv
// Byte-stream input and result handshake bundle for track_predictor_core.
// The core connects as slave; the byte source / result consumer side is master.
interface track_predictor_core_if #(
    parameter int CH = 2
);
    logic [7:0]      in_data;
    logic            in_valid;
    logic            out_valid;
    logic            out_ready;
    logic [8*CH-1:0] out_pos;
    logic [9*CH-1:0] out_vel;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_valid, out_pos, out_vel
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_valid, out_pos, out_vel
    );
endinterface

// File: rtl/track_predictor_core.sv
// Deframes A5-headed, XOR-checked position samples, keeps a per-channel history ring
// and emits linearly extrapolated position plus signed velocity through valid/ready.
module track_predictor_core #(
    parameter int CH        = 2,
    parameter int DEPTH     = 16,
    parameter int SPAN      = 4,
    parameter int VSHIFT    = 2,
    parameter int LOOKAHEAD = 2,
    parameter int DEDUP     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    track_predictor_core_if.slave bus,
    input  logic                  mode,
    input  logic                  flush,
    output logic                  warm,
    output logic                  overrun,
    output logic [7:0]            frame_err_cnt
);
    localparam int PW = 8 * CH;
    localparam int VW = 9 * CH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(CH + 1);
    localparam logic signed [12:0] LA = 13'(LOOKAHEAD);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   byte_idx;
    logic [PW-1:0]   pay_p0, pay_p1, last_pay;
    logic            last_vld;
    logic [7:0]      csum;
    logic            csum_ok, csum_bad, is_dup, accept_p0;
    logic            vld_p1, vld_p2;
    logic [PW-1:0]   hist_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count, count_nx;
    logic [PW-1:0]   newest_p2, old_p2;
    logic [PW-1:0]   res_pos;
    logic [VW-1:0]   res_vel;
    logic            out_valid_q;
    logic [PW-1:0]   out_pos_q;
    logic [VW-1:0]   out_vel_q;

    function automatic logic [7:0] clamp_u8(input logic signed [12:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 13'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    function automatic logic signed [8:0] velocity(input logic [7:0] nw, input logic [7:0] od);
        logic signed [8:0] diff;
        diff = $signed({1'b0, nw}) - $signed({1'b0, od});
        return diff >>> VSHIFT;
    endfunction

    function automatic logic [7:0] predict(input logic [7:0] nw, input logic signed [8:0] vel);
        logic signed [12:0] sum;
        sum = $signed({5'b0, nw}) + $signed({{4{vel[8]}}, vel}) * LA;
        return clamp_u8(sum);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= HUNT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.in_valid) begin
            case (state)
                HUNT:    if (bus.in_data == 8'hA5) state_nx = PAYLOAD;
                PAYLOAD: if (byte_idx == IW'(CH - 1)) state_nx = CHECK;
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            byte_idx <= '0;
        else if (bus.in_valid) begin
            if (state == HUNT)
                byte_idx <= '0;
            else if (state == PAYLOAD)
                byte_idx <= byte_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++)
            if (bus.in_valid && state == PAYLOAD && byte_idx == IW'(c))
                pay_p0[8*c +: 8] <= bus.in_data;
    end

    always_comb begin
        csum = '0;
        for (int c = 0; c < CH; c++)
            csum = csum ^ pay_p0[8*c +: 8];
    end

    assign csum_ok   = bus.in_valid && (state == CHECK) && (bus.in_data == csum);
    assign csum_bad  = bus.in_valid && (state == CHECK) && (bus.in_data != csum);
    assign is_dup    = (DEDUP != 0) && last_vld && (pay_p0 == last_pay);
    assign accept_p0 = csum_ok && !is_dup && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_err_cnt <= '0;
        else if (csum_bad && frame_err_cnt != 8'hFF)
            frame_err_cnt <= frame_err_cnt + 8'd1;
    end

    // p0 -> p1: accepted payload is staged for the history write
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= accept_p0;
    end

    always_ff @(posedge clk) begin
        if (accept_p0)
            pay_p1 <= pay_p0;
    end

    // p1 -> p2: history write, newest/old sample capture, warm update
    assign count_nx = (count == CW'(DEPTH)) ? count : count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2   <= 1'b0;
            wr_ptr   <= '0;
            count    <= '0;
            warm     <= 1'b0;
            last_vld <= 1'b0;
        end else if (flush) begin
            vld_p2   <= 1'b0;
            wr_ptr   <= '0;
            count    <= '0;
            warm     <= 1'b0;
            last_vld <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                wr_ptr   <= wr_ptr + 1'b1;
                count    <= count_nx;
                warm     <= (count_nx >= CW'(SPAN + 1));
                last_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1 && !flush) begin
            hist_mem[wr_ptr] <= pay_p1;
            last_pay         <= pay_p1;
            newest_p2        <= pay_p1;
            old_p2           <= hist_mem[wr_ptr - AW'(SPAN)];
        end
    end

    always_comb begin
        res_pos = newest_p2;
        res_vel = '0;
        if (mode && warm) begin
            for (int c = 0; c < CH; c++) begin
                res_vel[9*c +: 9] = velocity(newest_p2[8*c +: 8], old_p2[8*c +: 8]);
                res_pos[8*c +: 8] = predict(newest_p2[8*c +: 8], res_vel[9*c +: 9]);
            end
        end
    end

    // p2 -> out: load result; overwriting an unaccepted one flags overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            overrun     <= 1'b0;
            out_pos_q   <= '0;
            out_vel_q   <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            overrun     <= 1'b0;
        end else if (vld_p2) begin
            out_valid_q <= 1'b1;
            out_pos_q   <= res_pos;
            out_vel_q   <= res_vel;
            if (out_valid_q && !bus.out_ready)
                overrun <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pos   = out_pos_q;
    assign bus.out_vel   = out_vel_q;
endmodule

// File: tb/tb_track_predictor_core.sv
// Directed plus randomized bench for track_predictor_core; two instances (DEDUP=1 and 0)
// share one byte stream and are compared against a queue-based reference model.
module tb_track_predictor_core;
    localparam int CH = 2, DEPTH = 16, SPAN = 4, VSHIFT = 2, LA = 2;

    logic       clk = 1'b0;
    logic       reset, mode, flush;
    logic       warm1, ovr1, warm0, ovr0;
    logic [7:0] ferr1, ferr0;
    int         n_chk = 0, n_pass = 0, n_fail = 0;

    track_predictor_core_if #(.CH(CH)) bus1 ();
    track_predictor_core_if #(.CH(CH)) bus0 ();

    assign bus0.in_data   = bus1.in_data;
    assign bus0.in_valid  = bus1.in_valid;
    assign bus0.out_ready = bus1.out_ready;

    track_predictor_core #(.CH(CH), .DEPTH(DEPTH), .SPAN(SPAN), .VSHIFT(VSHIFT),
                           .LOOKAHEAD(LA), .DEDUP(1)) u_dut (
        .clk(clk), .reset(reset), .bus(bus1), .mode(mode), .flush(flush),
        .warm(warm1), .overrun(ovr1), .frame_err_cnt(ferr1));

    track_predictor_core #(.CH(CH), .DEPTH(DEPTH), .SPAN(SPAN), .VSHIFT(VSHIFT),
                           .LOOKAHEAD(LA), .DEDUP(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .mode(mode), .flush(flush),
        .warm(warm0), .overrun(ovr0), .frame_err_cnt(ferr0));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: index 1 = DEDUP on, index 0 = DEDUP off
    logic [15:0] m_hist [2][$];
    int          m_cnt [2];
    logic [15:0] m_last [2];
    bit          m_lvld [2];
    int          m_err;
    bit          e_got [2];
    logic [15:0] e_pos [2];
    logic [17:0] e_vel [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        for (int k = 0; k < 2; k++) begin
            m_hist[k].delete();
            m_cnt[k]  = 0;
            m_lvld[k] = 1'b0;
        end
    endtask

    task automatic model_reset();
        model_flush();
        m_err = 0;
    endtask

    task automatic model_accept(input logic [15:0] pay);
        logic [15:0] oldw;
        int n, o, d, v, p;
        for (int k = 0; k < 2; k++) begin
            e_got[k] = !(k == 1 && m_lvld[k] && m_last[k] == pay);
            if (e_got[k]) begin
                m_hist[k].push_back(pay);
                if (m_hist[k].size() > SPAN + 1) void'(m_hist[k].pop_front());
                if (m_cnt[k] < DEPTH) m_cnt[k]++;
                m_last[k] = pay;
                m_lvld[k] = 1'b1;
                e_pos[k]  = pay;
                e_vel[k]  = '0;
                if (mode && m_cnt[k] >= SPAN + 1) begin
                    oldw = m_hist[k][0];
                    for (int c = 0; c < CH; c++) begin
                        n = int'(pay[8*c +: 8]);
                        o = int'(oldw[8*c +: 8]);
                        d = n - o;
                        v = (d >= 0) ? d / (1 << VSHIFT)
                                     : -((-d + (1 << VSHIFT) - 1) / (1 << VSHIFT));
                        p = n + v * LA;
                        if (p < 0) p = 0;
                        else if (p > 255) p = 255;
                        e_pos[k][8*c +: 8] = 8'(p);
                        e_vel[k][9*c +: 9] = 9'(v);
                    end
                end
            end
        end
    endtask

    task automatic put_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk); #1;
        end
        bus1.in_data  = b;
        bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        bus1.in_data  = 8'($urandom);
    endtask

    function automatic int rg(input int gmax);
        return (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
    endfunction

    task automatic verify(input string tag);
        @(posedge clk); #1;
        check({tag, ".v1_n1"}, bus1.out_valid, 0);
        check({tag, ".v0_n1"}, bus0.out_valid, 0);
        check({tag, ".warm1"}, warm1, (m_cnt[1] >= SPAN + 1));
        check({tag, ".warm0"}, warm0, (m_cnt[0] >= SPAN + 1));
        @(posedge clk); #1;
        check({tag, ".v1_n2"}, bus1.out_valid, e_got[1]);
        check({tag, ".v0_n2"}, bus0.out_valid, e_got[0]);
        if (e_got[1]) begin
            check({tag, ".pos1"}, bus1.out_pos, e_pos[1]);
            check({tag, ".vel1"}, bus1.out_vel, e_vel[1]);
        end
        if (e_got[0]) begin
            check({tag, ".pos0"}, bus0.out_pos, e_pos[0]);
            check({tag, ".vel0"}, bus0.out_vel, e_vel[0]);
        end
        check({tag, ".ferr1"}, ferr1, m_err);
        check({tag, ".ferr0"}, ferr0, m_err);
    endtask

    task automatic send_frame(input logic [15:0] pay, input logic [7:0] cmask,
                              input bit chk, input int gmax, input string tag);
        logic [7:0] cs;
        cs = pay[7:0] ^ pay[15:8] ^ cmask;
        put_byte(8'hA5, rg(gmax));
        put_byte(pay[7:0], rg(gmax));
        put_byte(pay[15:8], rg(gmax));
        put_byte(cs, rg(gmax));
        if (cmask != 8'h00) begin
            if (m_err < 255) m_err++;
            e_got[0] = 1'b0;
            e_got[1] = 1'b0;
        end else begin
            model_accept(pay);
        end
        if (chk) verify(tag);
    endtask

    task automatic do_flush(input string tag);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
        check({tag, ".fl_v1"}, bus1.out_valid, 0);
        check({tag, ".fl_ovr1"}, ovr1, 0);
        check({tag, ".fl_warm1"}, warm1, 0);
        check({tag, ".fl_v0"}, bus0.out_valid, 0);
    endtask

    initial begin
        logic [15:0] pay, prev;
        logic [7:0]  g, cm;

        reset = 1'b1; mode = 1'b1; flush = 1'b0;
        bus1.in_data = 8'h00; bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", bus1.out_valid, 0);
        check("rst.pos", bus1.out_pos, 0);
        check("rst.vel", bus1.out_vel, 0);
        check("rst.warm", warm1, 0);
        check("rst.ovr", ovr1, 0);
        check("rst.ferr", ferr1, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ramp: ch0 100..132 step 8, ch1 constant 50
        for (int i = 0; i < 5; i++)
            send_frame({8'd50, 8'(100 + 8 * i)}, 8'h00, 1'b1, 0, "ramp");
        check("ramp.pos5", bus1.out_pos, {8'd50, 8'd148});
        check("ramp.vel5", bus1.out_vel, {9'd0, 9'd8});
        check("ramp.warm5", warm1, 1);

        // upper clamp, then lower clamp with negative velocity
        do_flush("clampA");
        for (int i = 0; i < 5; i++)
            send_frame({8'd7, 8'(200 + 12 * i)}, 8'h00, 1'b1, 0, "clamp_hi");
        check("clamp_hi.pos", bus1.out_pos, {8'd7, 8'd255});
        check("clamp_hi.vel", bus1.out_vel, {9'd0, 9'd12});
        do_flush("clampB");
        for (int i = 0; i < 5; i++)
            send_frame({8'd7, 8'(40 - 10 * i)}, 8'h00, 1'b1, 0, "clamp_lo");
        check("clamp_lo.pos", bus1.out_pos, {8'd7, 8'd0});
        check("clamp_lo.vel", bus1.out_vel, {9'd0, 9'h1F6});

        // bad checksum followed by a good frame
        do_flush("badck");
        send_frame(16'h2010, 8'h30, 1'b1, 0, "badck");
        check("badck.ferr", ferr1, 1);
        send_frame(16'h2010, 8'h00, 1'b1, 0, "goodck");
        check("goodck.pos", bus1.out_pos, 16'h2010);

        // header value inside payload is data
        send_frame(16'hA5A5, 8'h00, 1'b1, 1, "a5pay");

        // backpressure and overrun
        do_flush("bp");
        bus1.out_ready = 1'b0;
        send_frame(16'h0201, 8'h00, 1'b0, 0, "bpA");
        repeat (2) begin @(posedge clk); #1; end
        check("bpA.valid", bus1.out_valid, 1);
        check("bpA.pos", bus1.out_pos, 16'h0201);
        check("bpA.ovr", ovr1, 0);
        send_frame(16'h0403, 8'h00, 1'b0, 0, "bpB");
        repeat (3) begin @(posedge clk); #1; end
        check("bpB.valid", bus1.out_valid, 1);
        check("bpB.pos", bus1.out_pos, 16'h0403);
        check("bpB.ovr1", ovr1, 1);
        check("bpB.ovr0", ovr0, 1);
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.drop", bus1.out_valid, 0);
        check("bp.ovr_sticky", ovr1, 1);
        repeat (3) begin @(posedge clk); #1; end
        check("bp.ovr_hold", ovr1, 1);
        do_flush("bp_clr");

        // dedup: second identical frame dropped only where DEDUP=1
        send_frame(16'h3344, 8'h00, 1'b1, 0, "dupA");
        send_frame(16'h3344, 8'h00, 1'b1, 0, "dupB");
        check("dupB.v1", bus1.out_valid, 0);
        check("dupB.v0", bus0.out_valid, 1);
        do_flush("dup_fl");
        send_frame(16'h3344, 8'h00, 1'b1, 0, "dupC");
        check("dupC.v1", bus1.out_valid, 1);

        // flush while a frame is in flight discards it
        send_frame(16'h5566, 8'h00, 1'b0, 0, "inflt");
        do_flush("inflt");
        @(posedge clk); #1;
        check("inflt.v1", bus1.out_valid, 0);
        check("inflt.v0", bus0.out_valid, 0);

        // error counter saturation
        for (int i = 0; i < 260; i++)
            send_frame(16'($urandom), 8'h01, 1'b0, 0, "sat");
        repeat (2) begin @(posedge clk); #1; end
        check("sat.ferr1", ferr1, 255);
        check("sat.ferr0", ferr0, m_err);

        // randomized traffic
        prev = 16'h0000;
        for (int i = 0; i < 120; i++) begin
            mode = ($urandom_range(3, 0) != 0);
            if ($urandom_range(19, 0) == 0) do_flush("rnd");
            for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                put_byte(g, 0);
            end
            pay = ($urandom_range(3, 0) == 0) ? prev : 16'($urandom);
            cm  = ($urandom_range(6, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            send_frame(pay, cm, 1'b1, 2, "rnd");
            if (cm == 8'h00) prev = pay;
        end

        // async reset mid-frame aborts it
        mode = 1'b1;
        put_byte(8'hA5, 0);
        put_byte(8'h10, 0);
        #2 reset = 1'b1;
        #1;
        check("arst.valid", bus1.out_valid, 0);
        check("arst.pos", bus1.out_pos, 0);
        check("arst.ferr", ferr1, 0);
        check("arst.warm", warm1, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        put_byte(8'h20, 0);
        put_byte(8'h30, 0);
        send_frame(16'h2211, 8'h00, 1'b1, 0, "arst");
        check("arst.pos_out", bus1.out_pos, 16'h2211);
        check("arst.ferr_after", ferr1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/track_predictor_core.md
Name: track_predictor_core

Overview:
Parametrised multi-channel trajectory predictor for the guidance path. It consumes the byte stream from the UART receiver and extracts framed position samples with a checksum. Accepted samples go into a ring-buffer history. The block emits linearly extrapolated positions and signed velocities per channel through a valid/ready handshake, which feeds the servo PWM generators and the telemetry TX sequencer.

Parameters:
CH, 2, number of coordinate channels (1..4), one byte each per frame
DEPTH, 16, history depth per channel; power of two, >= SPAN+1
SPAN, 4, sample distance used for velocity difference
VSHIFT, 2, arithmetic right shift applied to the difference to form velocity
LOOKAHEAD, 2, integer multiplier of velocity added to newest sample (0..7)
DEDUP, 1, 1 = discard frames whose payload equals the last accepted payload

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_data  in  8  received byte
in_valid  in  1  one-cycle strobe, in_data valid
mode  in  1  0 = pass-through, 1 = predict
flush  in  1  synchronous clear of history and pending output
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_pos  out  8*CH  predicted position, channel 0 in LSBs, unsigned, clamped 0..255
out_vel  out  9*CH  signed two's-complement velocity per channel, channel 0 in LSBs
warm  out  1  history holds >= SPAN+1 samples
overrun  out  1  sticky: a result was overwritten before acceptance
frame_err_cnt  out  8  saturating count of checksum failures

Behaviour:
- Reset (async): all outputs 0. FSM = HUNT. History count 0. Last-payload marker invalid. Ring pointer 0.
- Frame format: header 0xA5, then CH payload bytes, then checksum = XOR of the payload bytes. Framing is length-based. 0xA5 inside the payload or checksum is data.
- FSM, advancing only on in_valid:
  - HUNT: 0xA5 -> PAYLOAD (byte index 0); any other byte is ignored.
  - PAYLOAD: store the byte; after the CH-th byte -> CHECK.
  - CHECK: match -> accept the frame, go to HUNT. Mismatch -> frame_err_cnt+1 (saturates at 255), discard the frame, go to HUNT.
- Accept at cycle N (the checksum strobe):
  - If DEDUP=1, the last-payload marker is valid and the payload equals it: drop the frame; no history write, no output.
  - Otherwise, at N+1 write the ring buffer at the pointer, advance the pointer modulo DEPTH, increment count (saturates at DEPTH), and update the last payload.
  - At N+2 load the output register and assert out_valid. Latency is 2 cycles from the checksum strobe to out_valid.
- Arithmetic per channel, with newest = sample just written and old = sample SPAN writes earlier:
  - diff = newest − old as 9-bit signed (range −255..255).
  - vel = diff >>> VSHIFT (sign-preserving).
  - pred = newest + vel*LOOKAHEAD, computed in at least 13-bit signed, then clamped to 0..255.
- Output by mode and warm:
  - mode=1 and warm: out_pos = pred, out_vel = vel.
  - mode=1 and not warm: out_pos = newest, out_vel = 0.
  - mode=0: out_pos = newest, out_vel = 0 regardless of warm. History still updates.
  - mode is sampled at the N+2 cycle.
- Handshake:
  - The result holds stable while out_valid=1 and out_ready=0.
  - out_valid and out_ready both high completes the transfer; out_valid drops next cycle unless a new result loads that same cycle.
  - A new result arriving while the previous is unaccepted overwrites it, keeps out_valid=1 and sets overrun.
- overrun clears only on reset or flush.
- flush (synchronous):
  - Clears count, warm, out_valid, overrun and the last-payload marker; the pointer returns to 0. frame_err_cnt and FSM state are unaffected.
  - A frame accepted in the same cycle as flush, or in flight in the N+1/N+2 stages, is discarded; flush wins.
- warm = (count >= SPAN+1), updated the same cycle as the history write.
- Reset asserted mid-frame aborts the frame; subsequent bytes are ignored until the next 0xA5.

Test Plan:
- Default params, mode=1, frames with ch0 = 100,108,116,124,132 and ch1 = 50 constant, out_ready=1 -> five out_valid pulses, each 2 cycles after its checksum byte. warm rises on the 5th write; 5th result ch0 = 148, vel 8; ch1 = 50, vel 0. The first four results equal the raw samples with vel 0.
- Clamp: ch0 = 200,212,224,236,248 -> vel 12, pred 255. Then flush, and ch0 = 40,30,20,10,0 -> vel −10 (9'h1F6), pred 0.
- Bad checksum: A5 10 20 00 -> no out_valid, frame_err_cnt=1. Next valid frame A5 10 20 30 -> accepted, out_pos = {20,10}.
- Backpressure: out_ready=0, two distinct valid frames -> out_valid held, out_pos equals the second frame, overrun=1. After out_ready=1 for one cycle, out_valid=0 and overrun stays 1 until flush.
- Dedup: identical frame sent twice -> one out_valid, count=1. With DEDUP=0 -> two results, count=2.
- Async reset asserted after bytes A5 10, then 20 30 A5 11 22 33 -> the first partial frame is ignored; only {22,11} is output, and frame_err_cnt stays 0.
